mips_multicycle_ctrl: RTL and testbench

- Main control FSM for the multi-cycle MIPS datapath that follows the single-cycle CPU.
- Sequences IF, ID, EX, MEM and WB over 3–5 cycles per instruction, with a memory-ready handshake.
- Drives every datapath mux and strobe, plus a single PC enable.
- Sits beside the register file, ALU, IR and unified memory inside the CPU top.

---
 rtl/mips_multicycle_ctrl.sv | 209 ++++++++++++++++++++
 tb/tb_mips_multicycle_ctrl.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: sequences IF/ID/EX/MEM/WB with a memory-ready handshake.
// Optional MC_PERF_CNT_EN adds retired-instruction and cycle counters.
module mips_multicycle_ctrl #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic [5:0]  opcode,
  input  logic        zero,
  input  logic        mem_ready,
  output logic        pc_en,
  output logic [1:0]  pc_source,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        reg_write,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic [1:0]  alu_op,
`ifdef MC_PERF_CNT_EN
  output logic [31:0] retired_cnt,
  output logic [31:0] cycle_cnt,
`endif
  output logic [3:0]  state,
  output logic        instr_done,
  output logic        illegal,
  output logic        mem_timeout
);

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    MEM_ADDR  = 4'd2,
    MEM_READ  = 4'd3,
    MEM_WB    = 4'd4,
    MEM_WRITE = 4'd5,
    EXECUTE   = 4'd6,
    ALU_WB    = 4'd7,
    BRANCH    = 4'd8,
    JUMP      = 4'd9,
    ADDI_EX   = 4'd10,
    ADDI_WB   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT_MAX - 1);

  state_t     state_q;
  state_t     state_d;
  logic [3:0] wait_cnt;
  logic       pc_write;
  logic       pc_write_cond;
  logic       waiting;
  logic       timeout_hit;

  assign state   = state_q;
  assign waiting = ((state_q == FETCH) || (state_q == MEM_READ) || (state_q == MEM_WRITE)) && !mem_ready;
  assign timeout_hit = (MEM_WAIT_MAX != 0) && waiting && (wait_cnt == WAIT_LAST);

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q     <= FETCH;
      wait_cnt    <= 4'd0;
      mem_timeout <= 1'b0;
    end else if (timeout_hit) begin
      state_q     <= FETCH;
      wait_cnt    <= 4'd0;
      mem_timeout <= 1'b1;
    end else begin
      state_q  <= state_d;
      wait_cnt <= waiting ? wait_cnt + 4'd1 : 4'd0;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'd0;
    i_or_d        = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    reg_write     = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = 2'd0;
    instr_done    = 1'b0;
    illegal       = 1'b0;

    case (state_q)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'd1;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        alu_src_b = 2'd3;
        case (opcode)
          OP_LW, OP_SW: state_d = MEM_ADDR;
          OP_RTYPE:     state_d = EXECUTE;
          OP_BEQ:       state_d = BRANCH;
          OP_J:         state_d = JUMP;
          OP_ADDI:      state_d = ADDI_EX;
          default: begin
            state_d    = FETCH;
            illegal    = 1'b1;
            instr_done = 1'b1;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      end
      MEM_READ: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) state_d = MEM_WB;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEM_WRITE: begin
        mem_write  = 1'b1;
        i_or_d     = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_d = FETCH;
      end
      EXECUTE: begin
        alu_src_a = 1'b1;
        alu_op    = 2'd2;
        state_d   = ALU_WB;
      end
      ALU_WB: begin
        reg_write  = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      BRANCH: begin
        alu_src_a     = 1'b1;
        alu_op        = 2'd1;
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
        instr_done    = 1'b1;
        state_d       = FETCH;
      end
      JUMP: begin
        pc_write   = 1'b1;
        pc_source  = 2'd2;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      ADDI_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'd2;
        state_d   = ADDI_WB;
      end
      ADDI_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      default: state_d = FETCH;
    endcase

    // Reset aborts whatever is in flight: nothing may write or retire in that cycle.
    if (rst) begin
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
    pc_en = !rst && (pc_write || (pc_write_cond && zero));
  end

`ifdef MC_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (rst) begin
      retired_cnt <= 32'd0;
      cycle_cnt   <= 32'd0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (instr_done && !illegal) retired_cnt <= retired_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Bench for mips_multicycle_ctrl: instruction-level model expands each opcode into its phase sequence
// and a per-cycle compare process checks every output against it.
module tb_mips_multicycle_ctrl;

  logic       CLK = 1'b0;
  logic       rst;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_en, i_or_d, mem_read, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a;
  logic [1:0] pc_source, alu_src_b, alu_op;
  logic [3:0] state;
  logic       instr_done, illegal, mem_timeout;

  int n_vec = 0;
  int n_err = 0;
  bit model_tmo = 1'b0;
  logic [21:0] exp_q[$];
  logic [21:0] dut_vec;

  always #5 CLK = ~CLK;

  mips_multicycle_ctrl #(.MEM_WAIT_MAX(15)) dut (
    .CLK(CLK), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .pc_source(pc_source), .i_or_d(i_or_d), .mem_read(mem_read),
    .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .state(state), .instr_done(instr_done), .illegal(illegal), .mem_timeout(mem_timeout)
  );

  assign dut_vec = {state, pc_en, pc_source, i_or_d, mem_read, mem_write, ir_write, reg_dst,
                    mem_to_reg, reg_write, alu_src_a, alu_src_b, alu_op, instr_done, illegal, mem_timeout};

  function automatic bit is_legal(input logic [5:0] op);
    return (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
           (op == 6'b000100) || (op == 6'b000010) || (op == 6'b001000);
  endfunction

  // Expected output word for one cycle spent in a given phase of the instruction.
  function automatic logic [21:0] expect_vec(input int ph, input bit rdy, input bit z, input bit ill, input bit tmo);
    logic       e_pc_en, e_iord, e_mrd, e_mwr, e_irw, e_rdst, e_m2r, e_rw, e_asa, e_done, e_ill;
    logic [1:0] e_pcs, e_asb, e_aop;
    {e_pc_en, e_iord, e_mrd, e_mwr, e_irw, e_rdst, e_m2r, e_rw, e_asa, e_done, e_ill} = '0;
    {e_pcs, e_asb, e_aop} = '0;
    case (ph)
      0:  begin e_mrd = 1; e_asb = 1; e_irw = rdy; e_pc_en = rdy; end
      1:  begin e_asb = 3; e_ill = ill; e_done = ill; end
      2:  begin e_asa = 1; e_asb = 2; end
      3:  begin e_mrd = 1; e_iord = 1; end
      4:  begin e_rw = 1; e_m2r = 1; e_done = 1; end
      5:  begin e_mwr = 1; e_iord = 1; e_done = rdy; end
      6:  begin e_asa = 1; e_aop = 2; end
      7:  begin e_rw = 1; e_rdst = 1; e_done = 1; end
      8:  begin e_asa = 1; e_aop = 1; e_pc_en = z; e_pcs = 1; e_done = 1; end
      9:  begin e_pc_en = 1; e_pcs = 2; e_done = 1; end
      10: begin e_asa = 1; e_asb = 2; end
      11: begin e_rw = 1; e_done = 1; end
      default: ;
    endcase
    return {4'(ph), e_pc_en, e_pcs, e_iord, e_mrd, e_mwr, e_irw, e_rdst, e_m2r, e_rw,
            e_asa, e_asb, e_aop, e_done, e_ill, tmo};
  endfunction

  // Drive one cycle; opcode is only meaningful in DECODE/MEM_ADDR, so it is garbage elsewhere.
  task automatic apply_stimulus(input int ph, input logic [5:0] op, input bit rdy, input bit z);
    opcode    = (ph == 1 || ph == 2) ? op : 6'h3f;
    mem_ready = rdy;
    zero      = z;
    exp_q.push_back(expect_vec(ph, rdy, z, (ph == 1) && !is_legal(op), model_tmo));
    @(posedge CLK);
    #1;
  endtask

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expand an instruction into its phase list, stretching memory phases by the wait counts.
  task automatic run_instr(input logic [5:0] op, input bit z, input int fetch_wait, input int mem_wait);
    int ph[5];
    int n;
    ph[0] = 0; ph[1] = 1; n = 2;
    case (op)
      6'b100011: begin ph[2] = 2; ph[3] = 3; ph[4] = 4; n = 5; end
      6'b101011: begin ph[2] = 2; ph[3] = 5; n = 4; end
      6'b000000: begin ph[2] = 6; ph[3] = 7; n = 4; end
      6'b000100: begin ph[2] = 8; n = 3; end
      6'b000010: begin ph[2] = 9; n = 3; end
      6'b001000: begin ph[2] = 10; ph[3] = 11; n = 4; end
      default: n = 2;
    endcase
    for (int i = 0; i < n; i++) begin
      int w;
      w = (ph[i] == 0) ? fetch_wait : ((ph[i] == 3 || ph[i] == 5) ? mem_wait : 0);
      for (int k = 0; k <= w; k++) apply_stimulus(ph[i], op, (k == w), z);
    end
  endtask

  always @(negedge CLK) begin
    if (exp_q.size() != 0) begin
      logic [21:0] e;
      e = exp_q.pop_front();
      n_vec++;
      if (dut_vec !== e) begin
        n_err++;
        $display("[TB] FAIL cycle_outputs t=%0t actual=%h required=%h", $time, dut_vec, e);
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = 6'h00;
    @(posedge CLK); #1;
    check_output("rst_state", 32'(state), 32'd0);
    check_output("rst_pc_en", 32'(pc_en), 32'd0);
    check_output("rst_mem_read", 32'(mem_read), 32'd0);
    @(posedge CLK); #1;
    check_output("rst_state2", 32'(state), 32'd0);
    check_output("rst_timeout", 32'(mem_timeout), 32'd0);
    rst = 1'b0;
    #1;
    check_output("first_fetch_pc_en", 32'(pc_en), 32'd1);

    run_instr(6'b100011, 1'b0, 0, 0);   // lw: 5 cycles
    run_instr(6'b000100, 1'b1, 0, 0);   // beq taken
    run_instr(6'b000100, 1'b0, 0, 0);   // beq not taken
    run_instr(6'b101011, 1'b0, 0, 3);   // sw, MEM_WRITE held 4 cycles
    run_instr(6'b111111, 1'b0, 0, 0);   // illegal
    run_instr(6'b000000, 1'b1, 0, 0);   // R-type
    run_instr(6'b001000, 1'b0, 0, 0);   // addi
    run_instr(6'b000010, 1'b0, 0, 0);   // j
    run_instr(6'b100011, 1'b0, 14, 14); // waits just below the timeout, counter clears between phases
    run_instr(6'b101011, 1'b1, 10, 10);

    // Hand-computed pin: lw reaches MEM_READ (3) on its 4th cycle.
    apply_stimulus(0, 6'b100011, 1'b1, 1'b0);
    apply_stimulus(1, 6'b100011, 1'b1, 1'b0);
    apply_stimulus(2, 6'b100011, 1'b1, 1'b0);
    mem_ready = 1'b0;
    #1;
    check_output("lw_cycle4_state", 32'(state), 32'd3);
    apply_stimulus(3, 6'b100011, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    check_output("abort_mem_read", 32'(mem_read), 32'd0);
    check_output("abort_reg_write", 32'(reg_write), 32'd0);
    check_output("abort_pc_en", 32'(pc_en), 32'd0);
    @(posedge CLK); #1;
    check_output("abort_state", 32'(state), 32'd0);
    rst = 1'b0;

    // Hold mem_ready low in FETCH: the 16th cycle is the first to show the timeout.
    for (int c = 1; c <= 20; c++) begin
      model_tmo = (c > 15);
      apply_stimulus(0, 6'h3f, 1'b0, 1'b0);
    end
    run_instr(6'b000010, 1'b0, 0, 0);
    check_output("timeout_sticky", 32'(mem_timeout), 32'd1);
    rst = 1'b1;
    model_tmo = 1'b0;
    @(posedge CLK); #1;
    check_output("timeout_cleared", 32'(mem_timeout), 32'd0);
    rst = 1'b0;
    run_instr(6'b001000, 1'b0, 0, 0);

    @(negedge CLK);
    #1;
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("[TB] FAIL queue_drain actual=%0d required=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
